// File: rtl/bsmodmul_pkg.sv
// Shared definitions for the bit-serial modular multiplier.
//   state_t   : controller states (IDLE waits for isync, RUN consumes serial bits)
//   ACC_GUARD : guard bits above LEN in the reduction intermediate
//   acc_width : width of the reduction intermediate for a given operand width
package bsmodmul_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // 2r + b < 3m < 2^(LEN+2), so two guard bits hold every intermediate.
  localparam int ACC_GUARD = 2;

  function automatic int acc_width(input int len);
    return len + ACC_GUARD;
  endfunction

endpackage

// File: rtl/bsmodmul_step.sv
// One interleaved modular-multiplication step: r_next = (2r + abit*b) mod m.
// The reduction uses two conditional subtractions. This is exact when r < m
// and b < m, because 2r + b then stays below 3m.
// Ports:
//   r      in  LEN  current accumulator
//   b      in  LEN  multiplicand
//   m      in  LEN  modulus
//   abit   in  1    current serial multiplier bit
//   r_next out LEN  reduced accumulator
module bsmodmul_step
  import bsmodmul_pkg::*;
#(
  parameter int LEN = 5
) (
  input  logic [LEN-1:0] r,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] m,
  input  logic           abit,
  output logic [LEN-1:0] r_next
);

  localparam int AW = acc_width(LEN);

  logic [AW-1:0] m_ext;
  logic [AW-1:0] sum;
  logic [AW-1:0] sub1;

  // Double, add the partial product, then reduce twice.
  always_comb begin
    m_ext = {{(AW-LEN){1'b0}}, m};
    sum   = {{(AW-LEN-1){1'b0}}, r, 1'b0}
          + (abit ? {{(AW-LEN){1'b0}}, b} : {AW{1'b0}});
    if (sum >= m_ext) begin
      sub1 = sum - m_ext;
    end else begin
      sub1 = sum;
    end
    if (sub1 >= m_ext) begin
      r_next = LEN'(sub1 - m_ext);
    end else begin
      r_next = sub1[LEN-1:0];
    end
  end

endmodule

// File: rtl/bsmodmul_var.sv
// Bit-serial modular multiplier with a runtime modulus: q = (a*b) mod m.
// The multiplier a arrives serially, MSB first. isync marks its first bit and
// samples b and m. The result appears LEN cycles after isync with a one-cycle
// osync pulse. An isync during RUN aborts the current operation and restarts.
// Ports:
//   clk   in  1    clock, rising edge
//   reset in  1    synchronous active-high reset
//   a     in  1    serial multiplier bit
//   b     in  LEN  multiplicand (sampled with isync)
//   m     in  LEN  modulus (sampled with isync)
//   isync in  1    start strobe, aligned with a[LEN-1]
//   q     out LEN  result, held until the next result
//   osync out 1    result-valid pulse
//   busy  out 1    operation in progress
//   err   out 1    operand error (m < 2 or b >= m), qualified by osync
module bsmodmul_var
  import bsmodmul_pkg::*;
#(
  parameter int LEN = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] m,
  input  logic           isync,
  output logic [LEN-1:0] q,
  output logic           osync,
  output logic           busy,
  output logic           err
);

  localparam int CW = $clog2(LEN);

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [LEN-1:0] r, r_n;
  logic [LEN-1:0] b_reg, b_n;
  logic [LEN-1:0] m_reg, m_n;
  logic           bad, bad_n;
  logic [LEN-1:0] q_n;
  logic           osync_n, busy_n, err_n;

  logic [LEN-1:0] step_r, step_b, step_m, step_out;

  // isync starts from r = 0 using the live b/m; otherwise use the registered operands.
  always_comb begin
    if (isync) begin
      step_r = {LEN{1'b0}};
      step_b = b;
      step_m = m;
    end else begin
      step_r = r;
      step_b = b_reg;
      step_m = m_reg;
    end
  end

  bsmodmul_step #(.LEN(LEN)) u_step (
    .r      (step_r),
    .b      (step_b),
    .m      (step_m),
    .abit   (a),
    .r_next (step_out)
  );

  // Next-state and output logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    r_n     = r;
    b_n     = b_reg;
    m_n     = m_reg;
    bad_n   = bad;
    q_n     = q;
    osync_n = 1'b0;
    busy_n  = busy;
    err_n   = err;
    if (isync) begin
      // A start has priority in either state; a running operation is dropped.
      b_n     = b;
      m_n     = m;
      bad_n   = (m < LEN'(2)) || (b >= m);
      r_n     = step_out;
      cnt_n   = CW'(1);
      state_n = RUN;
      busy_n  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          busy_n = 1'b0;
        end
        RUN: begin
          r_n = step_out;
          if (cnt == CW'(LEN - 1)) begin
            state_n = IDLE;
            cnt_n   = {CW{1'b0}};
            busy_n  = 1'b0;
            osync_n = 1'b1;
            err_n   = bad;
            q_n     = bad ? {LEN{1'b0}} : step_out;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = {CW{1'b0}};
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= {CW{1'b0}};
      r     <= {LEN{1'b0}};
      b_reg <= {LEN{1'b0}};
      m_reg <= {LEN{1'b0}};
      bad   <= 1'b0;
      q     <= {LEN{1'b0}};
      osync <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      r     <= r_n;
      b_reg <= b_n;
      m_reg <= m_n;
      bad   <= bad_n;
      q     <= q_n;
      osync <= osync_n;
      busy  <= busy_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_bsmodmul_var.sv
// Testbench for bsmodmul_var. Two instances are used, LEN=5 and LEN=8.
// A behavioural model rebuilds a from the serial bits and computes
// (a*b) mod m directly. It is checked against the DUT on every cycle, and
// directed scenarios pin the results with hand-computed literals.
module tb_bsmodmul_var;

  logic clk, reset;
  logic       isync5, a5;
  logic [4:0] b5, m5, q5;
  logic       osync5, busy5, err5;
  logic       isync8, a8;
  logic [7:0] b8, m8, q8;
  logic       osync8, busy8, err8;

  bsmodmul_var #(.LEN(5)) u5 (
    .clk(clk), .reset(reset), .a(a5), .b(b5), .m(m5), .isync(isync5),
    .q(q5), .osync(osync5), .busy(busy5), .err(err5)
  );
  bsmodmul_var #(.LEN(8)) u8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8), .m(m8), .isync(isync8),
    .q(q8), .osync(osync8), .busy(busy8), .err(err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit started = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model state, one slot per instance.
  bit     active   [2];
  int     nbits    [2];
  longint a_acc    [2];
  longint mb       [2];
  longint mm       [2];
  bit     exp_osync[2];
  longint exp_q    [2];
  bit     exp_err  [2];
  bit     exp_busy [2];

  task automatic model_step(input int i, input logic s, input logic ab,
                            input logic [7:0] bb, input logic [7:0] mv);
    int len;
    len = (i == 0) ? 5 : 8;
    exp_osync[i] = 1'b0;
    if (reset) begin
      active[i] = 1'b0; exp_q[i] = 0; exp_err[i] = 1'b0; exp_busy[i] = 1'b0;
    end else if (s) begin
      active[i] = 1'b1; nbits[i] = 1; a_acc[i] = longint'(ab);
      mb[i] = longint'(bb); mm[i] = longint'(mv); exp_busy[i] = 1'b1;
    end else if (active[i]) begin
      a_acc[i] = a_acc[i] * 2 + longint'(ab);
      nbits[i]++;
      if (nbits[i] == len) begin
        active[i] = 1'b0; exp_busy[i] = 1'b0; exp_osync[i] = 1'b1;
        if (mm[i] < 2 || mb[i] >= mm[i]) begin
          exp_q[i] = 0; exp_err[i] = 1'b1;
        end else begin
          exp_q[i] = (a_acc[i] * mb[i]) % mm[i]; exp_err[i] = 1'b0;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) started = 1'b1;
    model_step(0, isync5, a5, {3'b000, b5}, {3'b000, m5});
    model_step(1, isync8, a8, b8, m8);
  end

  // Observed result pulses.
  int rc0[$], rq0[$], re0[$];
  int rc1[$], rq1[$];

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("u5_osync", osync5, exp_osync[0]);
      chk("u5_busy",  busy5,  exp_busy[0]);
      chk("u5_q",     q5,     exp_q[0]);
      if (exp_osync[0]) chk("u5_err", err5, exp_err[0]);
      chk("u8_osync", osync8, exp_osync[1]);
      chk("u8_busy",  busy8,  exp_busy[1]);
      chk("u8_q",     q8,     exp_q[1]);
      if (exp_osync[1]) chk("u8_err", err8, exp_err[1]);
      if (osync5 === 1'b1) begin rc0.push_back(cyc); rq0.push_back(int'(q5)); re0.push_back(int'(err5)); end
      if (osync8 === 1'b1) begin rc1.push_back(cyc); rq1.push_back(int'(q8)); end
    end
  end

  // Drive one cycle of inputs for one instance, then wait for the next negedge.
  task automatic step_in(input int i, input logic s, input logic ab,
                         input logic [7:0] bb, input logic [7:0] mv);
    if (i == 0) begin
      isync5 = s; a5 = ab; b5 = bb[4:0]; m5 = mv[4:0];
    end else begin
      isync8 = s; a8 = ab; b8 = bb; m8 = mv;
    end
    @(negedge clk);
  endtask

  // Serial operation, MSB first. Only the first nb bits are driven. b/m are
  // randomised after the isync cycle because they must be ignored then.
  task automatic op(input int i, input int av, input int bv, input int mv, input int nb);
    int len;
    logic ab;
    len = (i == 0) ? 5 : 8;
    for (int k = 0; k < nb; k++) begin
      ab = 1'((av >> (len - 1 - k)) & 1);
      if (k == 0) step_in(i, 1'b1, ab, 8'(bv), 8'(mv));
      else        step_in(i, 1'b0, ab, 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      isync5 = 1'b0; a5 = 1'($urandom); b5 = 5'($urandom); m5 = 5'($urandom);
      isync8 = 1'b0; a8 = 1'($urandom); b8 = 8'($urandom); m8 = 8'($urandom);
      @(negedge clk);
    end
  endtask

  // One expected osync on u5 since index n0: its cycle, q and err.
  task automatic expect5(input string nm, input int n0, input int c, input int qv, input int ev);
    chk({nm, "_count"}, 64'(rq0.size() - n0), 64'(1));
    if (rq0.size() > n0) begin
      chk({nm, "_cycle"}, 64'(rc0[n0]), 64'(c));
      chk({nm, "_q"},     64'(rq0[n0]), 64'(qv));
      chk({nm, "_err"},   64'(re0[n0]), 64'(ev));
    end
  endtask

  int t, n0, n1;

  initial begin
    reset = 1'b1;
    isync5 = 1'b0; a5 = 1'b0; b5 = 5'd0; m5 = 5'd0;
    isync8 = 1'b0; a8 = 1'b0; b8 = 8'd0; m8 = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_q", q5, 64'd0);
    chk("rst_busy", busy5, 64'd0);
    chk("rst_osync", osync5, 64'd0);
    reset = 1'b0;
    idle(2);

    // a=1, b=16, m=29 -> 16 at t+5
    n0 = rq0.size(); t = cyc; op(0, 1, 16, 29, 5); idle(3);
    expect5("basic", n0, t + 5, 16, 0);

    // a=31, b=28 -> 868 mod 29 = 27
    n0 = rq0.size(); t = cyc; op(0, 31, 28, 29, 5); idle(3);
    expect5("max_a", n0, t + 5, 27, 0);

    // LEN=8: 200*250 = 50000 mod 251 = 51 at t+8
    n1 = rq1.size(); t = cyc; op(1, 200, 250, 251, 8); idle(3);
    chk("len8_count", 64'(rq1.size() - n1), 64'(1));
    if (rq1.size() > n1) begin
      chk("len8_cycle", 64'(rc1[n1]), 64'(t + 8));
      chk("len8_q", 64'(rq1[n1]), 64'(51));
    end

    // Error path b == m, then a valid op clears err: 3*5 = 15
    n0 = rq0.size(); t = cyc; op(0, 7, 29, 29, 5); idle(2);
    expect5("err_bm", n0, t + 5, 0, 1);
    n0 = rq0.size(); t = cyc; op(0, 3, 5, 29, 5); idle(2);
    expect5("err_clear", n0, t + 5, 15, 0);

    // Error path m < 2
    n0 = rq0.size(); t = cyc; op(0, 5, 0, 1, 5); idle(2);
    expect5("err_m1", n0, t + 5, 0, 1);

    // a = 0 -> 0
    n0 = rq0.size(); t = cyc; op(0, 0, 5, 29, 5); idle(2);
    expect5("zero_a", n0, t + 5, 0, 0);

    // Abort: restart at t+2 -> single result 15 at t+7
    n0 = rq0.size(); t = cyc; op(0, 1, 16, 29, 2); op(0, 3, 5, 29, 5); idle(3);
    expect5("abort", n0, t + 7, 15, 0);

    // Back-to-back: the second isync lands in the first osync cycle
    n0 = rq0.size(); t = cyc; op(0, 1, 16, 29, 5); op(0, 2, 16, 29, 5); idle(3);
    chk("b2b_count", 64'(rq0.size() - n0), 64'(2));
    if (rq0.size() > n0 + 1) begin
      chk("b2b_first_cycle", 64'(rc0[n0]), 64'(t + 5));
      chk("b2b_first_q", 64'(rq0[n0]), 64'(16));
      chk("b2b_second_cycle", 64'(rc0[n0 + 1]), 64'(t + 10));
      chk("b2b_second_q", 64'(rq0[n0 + 1]), 64'(3));
    end

    // Reset at t+3, together with an isync that it must override
    n0 = rq0.size(); t = cyc; op(0, 1, 16, 29, 3);
    reset = 1'b1; isync5 = 1'b1; a5 = 1'b1; b5 = 5'd16; m5 = 5'd29;
    @(negedge clk);
    reset = 1'b0;
    idle(7);
    chk("rst_mid_count", 64'(rq0.size() - n0), 64'(0));
    chk("rst_mid_q", q5, 64'd0);
    chk("rst_mid_busy", busy5, 64'd0);
    n0 = rq0.size(); t = cyc; op(0, 3, 5, 29, 5); idle(3);
    expect5("after_rst", n0, t + 5, 15, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
